// File: rtl/sic_exec_alu_pkg.sv
// Shared types for the SIC integer execution slot.
// Contents: alu_op_t, wb_sel_t, cf_kind_t, the sic_info_t / sic_packet_t packet
// layout and the ECR status encodings (ECR_BUSY / ECR_OK / ECR_BAD).
// Packet field widths are fixed here; the slot's ID_WIDTH / ECR_ID_WIDTH
// parameters are expected to match PKT_ID_WIDTH / PKT_ECR_ID_WIDTH.
package sic_exec_alu_pkg;

  localparam int unsigned PKT_ID_WIDTH     = 8;
  localparam int unsigned PKT_ECR_ID_WIDTH = 1;

  typedef enum logic [3:0] {
    ALU_ADDU,
    ALU_SUBU,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LUI,
    WB_LINK
  } wb_sel_t;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_JUMP_REG,
    CF_SYSCALL
  } cf_kind_t;

  // ECR lookup result
  localparam logic [1:0] ECR_BUSY = 2'b00;
  localparam logic [1:0] ECR_OK   = 2'b01;
  localparam logic [1:0] ECR_BAD  = 2'b10;

  typedef struct packed {
    logic        read_rs;
    logic        read_rt;
    logic        write_gpr;
    cf_kind_t    cf_kind;
    wb_sel_t     wb_sel;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        imm_zext;
    logic [15:0] imm16;
  } sic_info_t;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [PKT_ID_WIDTH-1:0]     issue_id;
    logic                        dep_ecr_valid;
    logic [PKT_ECR_ID_WIDTH-1:0] dep_ecr_id;
    sic_info_t                   info;
  } sic_packet_t;

endpackage

// File: rtl/sic_pkt_fifo.sv
// Generic packet buffer for the SIC slot.
// Ports: clk, rst (async, active-high), flush (clears pointers), push/din,
// pop/dout (head, valid while !empty), full, empty.
// Pointers carry one extra wrap bit so full/empty are told apart without a counter.
// A push while full or a pop while empty is ignored.
module sic_pkt_fifo
  import sic_exec_alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  sic_packet_t din,
  input  logic        pop,
  output sic_packet_t dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  sic_packet_t mem_q [DEPTH];
  logic        push_en, pop_en;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sic_exec_alu.sv
// SIC integer execution slot: LUI, LINK, JR and a reg/imm ALU.
// Packets are buffered in sic_pkt_fifo, then walked through
// IDLE -> OPERANDS -> EXECUTE -> WAIT_ECR -> COMMIT.
// Ports: clk, rst (async, active-high), flush; pkt_valid/pkt/pkt_ready ingress;
// rs/rt operand valid+data; ecr_read_en/addr/data speculation lookup;
// reg_wcommit/reg_wdata RF write; pc_redirect_* JR redirect; busy.
// Optional feature macro: SIC_EXEC_ALU_SHIFT_EN enables SLL/SRL/SRA. Without it,
// shift ops still flow through the FSM but never raise reg_wcommit.
module sic_exec_alu
  import sic_exec_alu_pkg::*;
#(
  parameter int unsigned SIC_ID       = 0,
  parameter int unsigned NUM_PHY_REGS = 64,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned ECR_ID_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    pkt_valid,
  input  sic_packet_t             pkt,
  output logic                    pkt_ready,
  input  logic                    rs_valid,
  input  logic                    rt_valid,
  input  logic [31:0]             rs_rdata,
  input  logic [31:0]             rt_rdata,
  output logic                    ecr_read_en,
  output logic [ECR_ID_WIDTH-1:0] ecr_read_addr,
  input  logic [1:0]              ecr_read_data,
  output logic                    reg_wcommit,
  output logic [31:0]             reg_wdata,
  output logic                    pc_redirect_valid,
  output logic [31:0]             pc_redirect_pc,
  output logic [ID_WIDTH-1:0]     pc_redirect_issue_id,
  output logic                    busy
);

  typedef enum logic [2:0] {
    StIdle,
    StOperands,
    StExecute,
    StWaitEcr,
    StCommit
  } state_t;

  state_t      state_q;
  sic_packet_t pkt_q;
  sic_packet_t fifo_dout;
  logic [31:0] rs_q, rt_q, result_q, jr_target_q;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        abort, operands_ready, shift_nop, commit_ok;
  logic [31:0] op_b, alu_res, wb_res;

  sic_pkt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (pkt_valid),
    .din  (pkt),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign pkt_ready = !fifo_full;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign busy      = !fifo_empty || (state_q != StIdle);

  assign ecr_read_en   = pkt_q.dep_ecr_valid && (state_q != StIdle);
  assign ecr_read_addr = ECR_ID_WIDTH'(pkt_q.dep_ecr_id);
  // A mispredicted dependency kills the packet wherever it is in the pipeline
  assign abort         = ecr_read_en && (ecr_read_data == ECR_BAD);

  assign operands_ready = (!pkt_q.info.read_rs || rs_valid) && (!pkt_q.info.read_rt || rt_valid);

  // ALU datapath works on captured operands during EXECUTE
  always_comb begin
    op_b = rt_q;
    if (pkt_q.info.use_imm) begin
      op_b = pkt_q.info.imm_zext ? {16'h0000, pkt_q.info.imm16}
                                 : {{16{pkt_q.info.imm16[15]}}, pkt_q.info.imm16};
    end
  end

`ifdef SIC_EXEC_ALU_SHIFT_EN
  logic [4:0] shamt;
  assign shamt = pkt_q.info.imm16[10:6];
`endif

  always_comb begin
    alu_res = 32'h0;
    unique case (pkt_q.info.alu_op)
      ALU_ADDU: alu_res = rs_q + op_b;
      ALU_SUBU: alu_res = rs_q - op_b;
      ALU_AND:  alu_res = rs_q & op_b;
      ALU_OR:   alu_res = rs_q | op_b;
      ALU_XOR:  alu_res = rs_q ^ op_b;
      ALU_NOR:  alu_res = ~(rs_q | op_b);
      ALU_SLT:  alu_res = {31'h0, $signed(rs_q) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'h0, rs_q < op_b};
`ifdef SIC_EXEC_ALU_SHIFT_EN
      ALU_SLL:  alu_res = rt_q << shamt;
      ALU_SRL:  alu_res = rt_q >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(rt_q) >>> shamt);
`endif
      default:  alu_res = 32'h0;
    endcase
  end

  always_comb begin
    wb_res = alu_res;
    unique case (pkt_q.info.wb_sel)
      WB_LUI:  wb_res = {pkt_q.info.imm16, 16'h0000};
      WB_LINK: wb_res = pkt_q.pc + 32'd4;
      default: wb_res = alu_res;
    endcase
  end

`ifdef SIC_EXEC_ALU_SHIFT_EN
  assign shift_nop = 1'b0;
`else
  // Without a shifter, shift ops complete as NOPs
  assign shift_nop = (pkt_q.info.wb_sel == WB_ALU) &&
                     (pkt_q.info.alu_op inside {ALU_SLL, ALU_SRL, ALU_SRA});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pkt_q       <= '0;
      rs_q        <= 32'h0;
      rt_q        <= 32'h0;
      result_q    <= 32'h0;
      jr_target_q <= 32'h0;
    end else if (flush || abort) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            pkt_q   <= fifo_dout;
            state_q <= StOperands;
          end
        end
        StOperands: begin
          if (operands_ready) begin
            rs_q    <= rs_rdata;
            rt_q    <= rt_rdata;
            state_q <= StExecute;
          end
        end
        StExecute: begin
          result_q <= wb_res;
          if (pkt_q.info.cf_kind == CF_JUMP_REG) jr_target_q <= rs_q;
          state_q <= StWaitEcr;
        end
        StWaitEcr: begin
          if (!pkt_q.dep_ecr_valid || (ecr_read_data == ECR_OK)) state_q <= StCommit;
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Commit pulses come from registered state, gated by same-cycle kill sources
  assign commit_ok = (state_q == StCommit) && !abort && !flush && !rst;

  assign reg_wcommit          = commit_ok && pkt_q.info.write_gpr && !shift_nop;
  assign reg_wdata            = result_q;
  assign pc_redirect_valid    = commit_ok && (pkt_q.info.cf_kind == CF_JUMP_REG);
  assign pc_redirect_pc       = jr_target_q;
  assign pc_redirect_issue_id = ID_WIDTH'(pkt_q.issue_id);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (commit_ok && (pkt_q.info.cf_kind == CF_SYSCALL)) begin
      $display("sic_exec_alu[%0d] (%0d phys regs): SYSCALL at pc %h", SIC_ID, NUM_PHY_REGS,
               pkt_q.pc);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sic_exec_alu.sv
// Scoreboard bench for sic_exec_alu: directed packets push expected commit /
// redirect events (data, issue id, cycle) into a queue; a negedge monitor pops
// and compares every pulse the DUT raises.
module tb_sic_exec_alu;
  import sic_exec_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        pkt_valid = 1'b0;
  sic_packet_t pkt = '0;
  logic        pkt_ready;
  logic        rs_valid = 1'b1, rt_valid = 1'b1;
  logic [31:0] rs_rdata = 32'h0, rt_rdata = 32'h0;
  logic        ecr_read_en;
  logic [0:0]  ecr_read_addr;
  logic [1:0]  ecr_read_data = ECR_OK;
  logic        reg_wcommit;
  logic [31:0] reg_wdata;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_pc;
  logic [7:0]  pc_redirect_issue_id;
  logic        busy;

  sic_exec_alu #(
    .SIC_ID(0), .NUM_PHY_REGS(64), .ID_WIDTH(8), .ECR_ID_WIDTH(1), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .pkt_valid(pkt_valid), .pkt(pkt),
    .pkt_ready(pkt_ready), .rs_valid(rs_valid), .rt_valid(rt_valid),
    .rs_rdata(rs_rdata), .rt_rdata(rt_rdata), .ecr_read_en(ecr_read_en),
    .ecr_read_addr(ecr_read_addr), .ecr_read_data(ecr_read_data),
    .reg_wcommit(reg_wcommit), .reg_wdata(reg_wdata),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_pc(pc_redirect_pc),
    .pc_redirect_issue_id(pc_redirect_issue_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          red;
    logic [31:0] data;
    logic [7:0]  id;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic mon(input bit red, input logic [31:0] d, input logic [7:0] id);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%0s: got data %h at cycle %0d, expected no output",
               red ? "redirect" : "wcommit", d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.red != red || e.data !== d || e.id !== id || (e.at >= 0 && e.at != cyc)) begin
        errors++;
        $display("FAIL sb_event: got red=%0d data=%h id=%h cycle=%0d, expected red=%0d data=%h id=%h cycle=%0d",
                 red, d, id, cyc, e.red, e.data, e.id, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wcommit) mon(1'b0, reg_wdata, 8'h00);
      if (pc_redirect_valid) mon(1'b1, pc_redirect_pc, pc_redirect_issue_id);
    end
  end

  function automatic sic_packet_t mk(input alu_op_t op, input wb_sel_t wb, input cf_kind_t cf,
                                     input logic rrs, input logic rrt, input logic wr,
                                     input logic ui, input logic zx, input logic [15:0] imm,
                                     input logic dep, input logic [31:0] pc,
                                     input logic [7:0] id);
    sic_packet_t p;
    p = '0;
    p.pc = pc;
    p.issue_id = id;
    p.dep_ecr_valid = dep;
    p.dep_ecr_id = dep;
    p.info.read_rs = rrs;
    p.info.read_rt = rrt;
    p.info.write_gpr = wr;
    p.info.cf_kind = cf;
    p.info.wb_sel = wb;
    p.info.alu_op = op;
    p.info.use_imm = ui;
    p.info.imm_zext = zx;
    p.info.imm16 = imm;
    return p;
  endfunction

  function automatic sic_packet_t rr(input alu_op_t op);
    return mk(op, WB_ALU, CF_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 8'h0);
  endfunction

  function automatic sic_packet_t ri(input alu_op_t op, input logic zx, input logic [15:0] imm);
    return mk(op, WB_ALU, CF_NONE, 1'b1, 1'b0, 1'b1, 1'b1, zx, imm, 1'b0, 32'h0, 8'h0);
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic send(input sic_packet_t p, output int t);
    int n;
    n = 0;
    pkt = p;
    pkt_valid = 1'b1;
    while (!pkt_ready && n < 50) begin
      step();
      n++;
    end
    if (!pkt_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got pkt_ready=0 for 50 cycles, expected 1");
    end
    t = cyc;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 after 100 cycles, expected 0");
    end
  endtask

  task automatic run(input sic_packet_t p, input logic [31:0] rsv, input logic [31:0] rtv,
                     input logic [31:0] want);
    int t;
    rs_rdata = rsv;
    rt_rdata = rtv;
    send(p, t);
    sb.push_back('{red: 1'b0, data: want, id: 8'h00, at: t + 5});
    wait_idle();
  endtask

  typedef struct {
    alu_op_t     op;
    logic [31:0] want;
  } vec_t;

  initial begin
    int t;
    vec_t vecs[5];
    vecs = '{'{ALU_SUBU, 32'h0E0FF1F0}, '{ALU_AND, 32'h000F000F}, '{ALU_OR, 32'h0FFF0FFF},
             '{ALU_XOR, 32'h0FF00FF0}, '{ALU_NOR, 32'hF000F000}};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_wcommit", reg_wcommit, 0);
    check("rst_redirect", pc_redirect_valid, 0);
    rst = 1'b0;
    step();
    check("rst_pkt_ready", pkt_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ecr_en", ecr_read_en, 0);
    check("rst_wdata", reg_wdata, 0);

    // ALU basics
    run(rr(ALU_ADDU), 32'hFFFFFFFF, 32'h1, 32'h0);
    run(ri(ALU_SLT, 1'b0, 16'h0001), 32'hFFFFFFFE, 32'h0, 32'h1);
    run(ri(ALU_SLTU, 1'b0, 16'h0001), 32'hFFFFFFFE, 32'h0, 32'h0);
    foreach (vecs[i]) run(rr(vecs[i].op), 32'h0F0F00FF, 32'h00FF0F0F, vecs[i].want);
    run(ri(ALU_ADDU, 1'b1, 16'h8000), 32'h1, 32'h0, 32'h00008001);
    run(ri(ALU_ADDU, 1'b0, 16'h8000), 32'h1, 32'h0, 32'hFFFF8001);
    run(mk(ALU_ADDU, WB_LINK, CF_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0,
           32'h00400010, 8'h3), 32'h0, 32'h0, 32'h00400014);

    // Operand stall: rs arrives 2 cycles late
    rs_valid = 1'b0;
    rs_rdata = 32'd5;
    rt_rdata = 32'd7;
    send(rr(ALU_ADDU), t);
    sb.push_back('{red: 1'b0, data: 32'd12, id: 8'h00, at: t + 7});
    wait_cyc(t + 4);
    rs_valid = 1'b1;
    wait_idle();

    // JR with ECR busy for three WAIT_ECR cycles
    ecr_read_data = ECR_BUSY;
    rs_rdata = 32'h00400100;
    send(mk(ALU_ADDU, WB_ALU, CF_JUMP_REG, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1,
            32'h0, 8'h5A), t);
    sb.push_back('{red: 1'b1, data: 32'h00400100, id: 8'h5A, at: t + 8});
    wait_cyc(t + 4);
    check("jr_ecr_en", ecr_read_en, 1);
    check("jr_ecr_addr", ecr_read_addr, 1);
    wait_cyc(t + 7);
    ecr_read_data = ECR_OK;
    wait_idle();

    // LUI killed by ECR in OPERANDS, then a good LUI
    ecr_read_data = ECR_BAD;
    send(mk(ALU_ADDU, WB_LUI, CF_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1,
            32'h0, 8'h1), t);
    wait_cyc(t + 2);
    check("abort_ecr_en", ecr_read_en, 1);
    wait_cyc(t + 3);
    check("abort_busy", busy, 0);
    ecr_read_data = ECR_OK;
    run(mk(ALU_ADDU, WB_LUI, CF_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1,
           32'h0, 8'h2), 32'h0, 32'h0, 32'h12340000);

    // Flush in the COMMIT cycle suppresses the write
    rs_rdata = 32'd3;
    rt_rdata = 32'd4;
    send(rr(ALU_ADDU), t);
    wait_cyc(t + 5);
    flush = 1'b1;
    #1;
    check("flush_commit_wcommit", reg_wcommit, 0);
    step();
    flush = 1'b0;
    check("flush_commit_busy", busy, 0);

    // Fill FIFO behind a stalled packet, then flush everything
    rs_valid = 1'b0;
    send(rr(ALU_ADDU), t);
    send(rr(ALU_SUBU), t);
    send(rr(ALU_OR), t);
    check("fifo_full_ready", pkt_ready, 0);
    check("fifo_full_busy", busy, 1);
    flush = 1'b1;
    #1;
    check("fifo_flush_wcommit", reg_wcommit, 0);
    step();
    flush = 1'b0;
    check("fifo_flush_busy", busy, 0);
    check("fifo_flush_ready", pkt_ready, 1);
    rs_valid = 1'b1;
    repeat (10) step();

    // Shifts
    rt_rdata = 32'h80000000;
    send(mk(ALU_SRA, WB_ALU, CF_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0,
            32'h0, 8'h0), t);
`ifdef SIC_EXEC_ALU_SHIFT_EN
    sb.push_back('{red: 1'b0, data: 32'hF8000000, id: 8'h00, at: t + 5});
`endif
    wait_cyc(t + 5);
    check("sra_busy_commit", busy, 1);
    wait_idle();
`ifdef SIC_EXEC_ALU_SHIFT_EN
    run(mk(ALU_SLL, WB_ALU, CF_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0,
           32'h0, 8'h0), 32'h0, 32'h80000001, 32'h00000010);
    run(mk(ALU_SRL, WB_ALU, CF_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0,
           32'h0, 8'h0), 32'h0, 32'h80000000, 32'h08000000);
`endif

    repeat (5) step();
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
